bram_uart_loader: RTL

- Serial boot loader that writes a program image into BRAM port B from a host UART link.
- Carries the return direction of the port-B path: the top currently only reads port B for the 7-segment display.
- Holds the CR16 core off (O_CPU_HOLD) while an image is loading, then releases it.
- Lets new machine code be loaded without resynthesising the BRAM init file.

---
 rtl/cr16_loader_pkg.sv | 28 ++
 rtl/bram_uart_loader_uart_rx.sv | 92 +++++++++
 rtl/bram_uart_loader.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/cr16_loader_pkg.sv
// Shared types and constants for the CR16 UART boot loader.
package cr16_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT_HI,
    S_COUNT_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CHECK,
    S_DONE,
    S_ERROR
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] P_LOADER_HEADER = 8'hA5;

  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/bram_uart_loader_uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling, glitch-rejecting start
// bit and stop-bit check. O_VALID / O_FRAME_ERROR are single-cycle pulses.
module uart_rx
  import cr16_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       I_CLK,
  input  logic       I_NRESET,
  input  logic       I_RX,
  output logic [7:0] O_BYTE,
  output logic       O_VALID,
  output logic       O_FRAME_ERROR
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t     state, state_next;
  logic          rx_meta, rx_sync, rx_prev;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;

  // Synchroniser plus one extra stage for falling-edge detection; idle high.
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= I_RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      state <= RX_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RX_IDLE:  if (rx_prev && !rx_sync) state_next = RX_START;
      RX_START: if (clk_cnt == HALF) state_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (clk_cnt == LAST && bit_idx == 3'd7) state_next = RX_STOP;
      RX_STOP:  if (clk_cnt == LAST) state_next = RX_IDLE;
      default:  state_next = RX_IDLE;
    endcase
  end

  // Bit timing: the counter restarts at each sample point so later samples
  // stay one bit period apart, centred on the bit.
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      case (state)
        RX_START: clk_cnt <= (clk_cnt == HALF) ? '0 : clk_cnt + CW'(1);
        RX_DATA: begin
          if (clk_cnt == LAST) begin
            clk_cnt   <= '0;
            shift_reg <= {rx_sync, shift_reg[7:1]};
            bit_idx   <= bit_idx + 3'd1;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        RX_STOP: clk_cnt <= (clk_cnt == LAST) ? '0 : clk_cnt + CW'(1);
        default: begin
          clk_cnt <= '0;
          bit_idx <= '0;
        end
      endcase
    end
  end

  always_comb begin
    O_BYTE        = shift_reg;
    O_VALID       = (state == RX_STOP) && (clk_cnt == LAST) && rx_sync;
    O_FRAME_ERROR = (state == RX_STOP) && (clk_cnt == LAST) && !rx_sync;
  end

endmodule

// File: rtl/bram_uart_loader.sv
// UART boot loader writing a program image into BRAM port B while holding the CR16 off.
// Optional trailer checksum enabled by defining CR16_LOADER_CHECKSUM_EN.
module bram_uart_loader
  import cr16_loader_pkg::*;
#(
  parameter int P_CLK_FREQ_HZ   = 50000000,
  parameter int P_BAUD          = 115200,
  parameter int P_ADDRESS_WIDTH = 10,
  parameter int P_START_ADDRESS = 0
) (
  input  logic                       I_CLK,
  input  logic                       I_NRESET,
  input  logic                       I_UART_RX,
  output logic [15:0]                O_MEM_DATA,
  output logic [P_ADDRESS_WIDTH-1:0] O_MEM_ADDRESS,
  output logic                       O_MEM_WRITE_ENABLE,
  output logic                       O_CPU_HOLD,
  output logic                       O_LOAD_DONE,
  output logic                       O_LOAD_ERROR
);

  localparam int CLKS_PER_BIT = clks_per_bit(P_CLK_FREQ_HZ, P_BAUD);
  localparam logic [P_ADDRESS_WIDTH-1:0] START_ADDR = P_ADDRESS_WIDTH'(P_START_ADDRESS);
`ifdef CR16_LOADER_CHECKSUM_EN
  localparam loader_state_t S_LAST = S_CHECK;
`else
  localparam loader_state_t S_LAST = S_DONE;
`endif

  loader_state_t              state, state_next;
  logic [7:0]                 rx_byte;
  logic                       rx_valid, rx_ferr, header_seen;
  logic [15:0]                word_total, word_cnt, mem_data;
  logic [7:0]                 hi_byte;
  logic [P_ADDRESS_WIDTH-1:0] mem_addr;
  logic                       mem_we;
`ifdef CR16_LOADER_CHECKSUM_EN
  logic [7:0]                 sum;
`endif

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_rx (
    .I_CLK        (I_CLK),
    .I_NRESET     (I_NRESET),
    .I_RX         (I_UART_RX),
    .O_BYTE       (rx_byte),
    .O_VALID      (rx_valid),
    .O_FRAME_ERROR(rx_ferr)
  );

  assign header_seen = rx_valid && (rx_byte == P_LOADER_HEADER);

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (header_seen) state_next = S_COUNT_HI;
      S_COUNT_HI: begin
        if (rx_ferr)       state_next = S_ERROR;
        else if (rx_valid) state_next = S_COUNT_LO;
      end
      S_COUNT_LO: begin
        if (rx_ferr)       state_next = S_ERROR;
        else if (rx_valid) state_next = ({word_total[15:8], rx_byte} == 16'd0) ? S_LAST : S_DATA_HI;
      end
      S_DATA_HI: begin
        if (rx_ferr)       state_next = S_ERROR;
        else if (rx_valid) state_next = S_DATA_LO;
      end
      // Leave only after the strobe cycle so the address is stable under it.
      S_DATA_LO: begin
        if (mem_we)       state_next = (word_cnt + 16'd1 == word_total) ? S_LAST : S_DATA_HI;
        else if (rx_ferr) state_next = S_ERROR;
      end
      S_CHECK: begin
`ifdef CR16_LOADER_CHECKSUM_EN
        if (rx_ferr)       state_next = S_ERROR;
        else if (rx_valid) state_next = (rx_byte == sum) ? S_DONE : S_ERROR;
`else
        state_next = S_IDLE;
`endif
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    O_CPU_HOLD   = (state != S_IDLE) && (state != S_DONE);
    O_LOAD_DONE  = (state == S_DONE);
    O_LOAD_ERROR = (state == S_ERROR);
  end

  // Datapath: count/byte latches, write strobe, and post-strobe address advance.
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      word_total <= '0;
      word_cnt   <= '0;
      hi_byte    <= '0;
      mem_data   <= '0;
      mem_addr   <= START_ADDR;
      mem_we     <= 1'b0;
`ifdef CR16_LOADER_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      if (mem_we) begin
        mem_addr <= mem_addr + P_ADDRESS_WIDTH'(1);
        word_cnt <= word_cnt + 16'd1;
      end
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (header_seen) begin
            mem_addr <= START_ADDR;
            word_cnt <= '0;
`ifdef CR16_LOADER_CHECKSUM_EN
            sum      <= '0;
`endif
          end
        end
        S_COUNT_HI: if (rx_valid) word_total[15:8] <= rx_byte;
        S_COUNT_LO: if (rx_valid) word_total[7:0] <= rx_byte;
        S_DATA_HI: begin
          if (rx_valid) begin
            hi_byte <= rx_byte;
`ifdef CR16_LOADER_CHECKSUM_EN
            sum     <= sum + rx_byte;
`endif
          end
        end
        S_DATA_LO: begin
          if (rx_valid) begin
            mem_data <= {hi_byte, rx_byte};
            mem_we   <= 1'b1;
`ifdef CR16_LOADER_CHECKSUM_EN
            sum      <= sum + rx_byte;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign O_MEM_DATA         = mem_data;
  assign O_MEM_ADDRESS      = mem_addr;
  assign O_MEM_WRITE_ENABLE = mem_we;

endmodule
